// File: rtl/stream_port_responder.sv
// stream_port_responder: PU-facing stream read/write FIFOs bridging memory fill and drain handshakes.
module stream_port_responder #(
    parameter int AXI_DATA_W = 64,
    parameter int RD_DEPTH   = 8,
    parameter int WR_DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     fill_valid,
    output logic                     fill_ready,
    input  logic [AXI_DATA_W-1:0]    fill_data,
    output logic                     stream_read_ready,
    input  logic                     stream_read_req,
    output logic [AXI_DATA_W-1:0]    stream_read_data,
    output logic                     stream_write_ready,
    input  logic                     stream_write_req,
    input  logic [AXI_DATA_W-1:0]    stream_write_data,
    output logic                     drain_valid,
    input  logic                     drain_ready,
    output logic [AXI_DATA_W-1:0]    drain_data,
    output logic [$clog2(RD_DEPTH):0] rd_count,
    output logic [$clog2(WR_DEPTH):0] wr_count,
    output logic                     err_underflow,
    output logic                     err_overflow
);
    localparam int RA = $clog2(RD_DEPTH);
    localparam int WA = $clog2(WR_DEPTH);

    logic [AXI_DATA_W-1:0] rd_mem [RD_DEPTH];
    logic [AXI_DATA_W-1:0] wr_mem [WR_DEPTH];
    logic [RA:0]           rd_wp_q, rd_wp_d, rd_rp_q, rd_rp_d;
    logic [WA:0]           wr_wp_q, wr_wp_d, wr_rp_q, wr_rp_d;
    logic [AXI_DATA_W-1:0] rd_data_q, rd_data_d;
    logic                  err_under_q, err_under_d, err_over_q, err_over_d;
    logic                  rd_full, rd_empty, wr_full, wr_empty;
    logic                  rd_push, rd_pop, wr_push, wr_pop;

    always_comb begin
        rd_full     = (rd_wp_q[RA] != rd_rp_q[RA]) && (rd_wp_q[RA-1:0] == rd_rp_q[RA-1:0]);
        rd_empty    = rd_wp_q == rd_rp_q;
        wr_full     = (wr_wp_q[WA] != wr_rp_q[WA]) && (wr_wp_q[WA-1:0] == wr_rp_q[WA-1:0]);
        wr_empty    = wr_wp_q == wr_rp_q;
        rd_push     = fill_valid && !rd_full;
        rd_pop      = stream_read_req && !rd_empty;
        wr_pop      = !wr_empty && drain_ready;
        // a full write FIFO still takes a word when its head leaves in the same cycle
        wr_push     = stream_write_req && (!wr_full || wr_pop);
        rd_wp_d     = rd_wp_q + (RA+1)'(rd_push);
        rd_rp_d     = rd_rp_q + (RA+1)'(rd_pop);
        wr_wp_d     = wr_wp_q + (WA+1)'(wr_push);
        wr_rp_d     = wr_rp_q + (WA+1)'(wr_pop);
        rd_data_d   = rd_pop ? rd_mem[rd_rp_q[RA-1:0]] : rd_data_q;
        err_under_d = err_under_q || (stream_read_req && rd_empty);
        err_over_d  = err_over_q || (stream_write_req && !wr_push);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            rd_wp_q     <= '0;
            rd_rp_q     <= '0;
            wr_wp_q     <= '0;
            wr_rp_q     <= '0;
            rd_data_q   <= '0;
            err_under_q <= 1'b0;
            err_over_q  <= 1'b0;
        end else begin
            rd_wp_q     <= rd_wp_d;
            rd_rp_q     <= rd_rp_d;
            wr_wp_q     <= wr_wp_d;
            wr_rp_q     <= wr_rp_d;
            rd_data_q   <= rd_data_d;
            err_under_q <= err_under_d;
            err_over_q  <= err_over_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_push) rd_mem[rd_wp_q[RA-1:0]] <= fill_data;
        if (wr_push) wr_mem[wr_wp_q[WA-1:0]] <= stream_write_data;
    end

    assign fill_ready         = !rd_full;
    assign stream_read_ready  = !rd_empty;
    assign stream_read_data   = rd_data_q;
    assign rd_count           = rd_wp_q - rd_rp_q;
    assign wr_count           = wr_wp_q - wr_rp_q;
    assign stream_write_ready = wr_count <= (WA+1)'(WR_DEPTH - 2);
    assign drain_valid        = !wr_empty;
    assign drain_data         = wr_mem[wr_rp_q[WA-1:0]];
    assign err_underflow      = err_under_q;
    assign err_overflow       = err_over_q;
endmodule
